// File: rtl/second_countdown.sv
// second_countdown: loadable 0-59 s BCD countdown timer with expiry pulse
// and a held alarm that lasts ALARM_TICKS enable ticks.
module second_countdown #(
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] load_ts,
  input  logic [3:0] load_ss,
  output logic [2:0] ts,
  output logic [3:0] ss,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int CW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ts_q, ts_d;
  logic [3:0]      ss_q, ss_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            load_ok;
  logic            count_zero;
  logic            count_one;
  logic [2:0]      ts_clamped;
  logic [3:0]      ss_clamped;

  // Load is simply absent while running, so stop/enable still act then.
  assign load_ok    = load && (state_q != S_RUN);
  assign count_zero = (ts_q == 3'd0) && (ss_q == 4'd0);
  assign count_one  = (ts_q == 3'd0) && (ss_q == 4'd1);
  assign ts_clamped = (load_ts > 3'd5) ? 3'd5 : load_ts;
  assign ss_clamped = (load_ss > 4'd9) ? 4'd9 : load_ss;

  // State register and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ts_q    <= 3'd0;
      ss_q    <= 4'd0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      ss_q    <= ss_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load > stop > start > enable; a control transition
  // consumes the cycle so no decrement happens alongside it.
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    ss_d    = ss_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    if (load_ok) begin
      state_d = S_IDLE;
      ts_d    = ts_clamped;
      ss_d    = ss_clamped;
      cnt_d   = '0;
    end else if (stop) begin
      case (state_q)
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_IDLE;
        S_ALARM: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: state_d = state_q;
      endcase
    end else if (start && (state_q == S_IDLE || state_q == S_PAUSE) && !count_zero) begin
      state_d = S_RUN;
    end else if (enable) begin
      case (state_q)
        S_RUN: begin
          if (ss_q != 4'd0) begin
            ss_d = ss_q - 4'd1;
          end else if (ts_q != 3'd0) begin
            ss_d = 4'd9;
            ts_d = ts_q - 3'd1;
          end
          if (count_one) begin
            state_d = S_ALARM;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        S_ALARM: begin
          if (cnt_q == CW'(ALARM_TICKS - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign ts      = ts_q;
  assign ss      = ss_q;
  assign done    = done_q;
  assign running = (state_q == S_RUN);
  assign alarm   = (state_q == S_ALARM);

endmodule

// File: tb/tb_second_countdown.sv
// tb_second_countdown: directed scenarios for the 0-59 s countdown timer.
module tb_second_countdown;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       load;
  logic       start;
  logic       stop;
  logic [2:0] load_ts;
  logic [3:0] load_ss;
  logic [2:0] ts;
  logic [3:0] ss;
  logic       running;
  logic       done;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  second_countdown #(.ALARM_TICKS(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .load    (load),
    .start   (start),
    .stop    (stop),
    .load_ts (load_ts),
    .load_ss (load_ss),
    .ts      (ts),
    .ss      (ss),
    .running (running),
    .done    (done),
    .alarm   (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock of strobes, then sample 1 time unit after the edge.
  task automatic cycle(input logic l, input logic sp, input logic st, input logic en);
    load   = l;
    stop   = sp;
    start  = st;
    enable = en;
    @(posedge clk);
    #1;
    load   = 1'b0;
    stop   = 1'b0;
    start  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    checks++;
    if (ts !== 3'd0 || ss !== 4'd0 || running !== 1'b0 || done !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ts=%0d ss=%0d run=%b done=%b alarm=%b, required 0 0 0 0 0",
               ts, ss, running, done, alarm);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset: ts=%0d ss=%0d", ts, ss);
  endtask

  task automatic test_basic;
    int exp;
    logic exp_done;
    logic exp_alarm;
    load_ts = 3'd2;
    load_ss = 4'd5;
    cycle(1, 0, 0, 0);
    checks++;
    if (ts !== 3'd2 || ss !== 4'd5 || running !== 1'b0) begin
      errors++;
      $display("FAIL basic_load: ts=%0d ss=%0d run=%b, required 2 5 0", ts, ss, running);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (running !== 1'b1 || ts !== 3'd2 || ss !== 4'd5) begin
      errors++;
      $display("FAIL basic_start: run=%b ts=%0d ss=%0d, required 1 2 5", running, ts, ss);
    end
    for (int k = 1; k <= 25; k++) begin
      cycle(0, 0, 0, 1);
      exp = 25 - k;
      exp_done = (k == 25);
      checks++;
      if (ts !== 3'(exp / 10) || ss !== 4'(exp % 10) || done !== exp_done
          || running !== !exp_done || alarm !== exp_done) begin
        errors++;
        $display("FAIL basic_count[%0d]: ts=%0d ss=%0d done=%b run=%b alarm=%b, required %0d %0d %b %b %b",
                 k, ts, ss, done, running, alarm, exp / 10, exp % 10, exp_done, !exp_done, exp_done);
      end
      $display("basic enable %0d: %0d%0d done=%b", k, ts, ss, done);
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (done !== 1'b0 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_width: done=%b alarm=%b, required 0 1", done, alarm);
    end
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 0, 0, 1);
      exp_alarm = (k < 5);
      checks++;
      if (alarm !== exp_alarm || ts !== 3'd0 || ss !== 4'd0 || done !== 1'b0 || running !== 1'b0) begin
        errors++;
        $display("FAIL basic_alarm[%0d]: alarm=%b ts=%0d ss=%0d done=%b, required %b 0 0 0",
                 k, alarm, ts, ss, done, exp_alarm);
      end
      $display("alarm enable %0d: alarm=%b", k, alarm);
    end
  endtask

  task automatic test_clamp;
    load_ts = 3'd7;
    load_ss = 4'd12;
    cycle(1, 0, 0, 0);
    checks++;
    if (ts !== 3'd5 || ss !== 4'd9) begin
      errors++;
      $display("FAIL clamp_both: ts=%0d ss=%0d, required 5 9", ts, ss);
    end
    load_ts = 3'd3;
    load_ss = 4'd15;
    cycle(1, 0, 0, 0);
    checks++;
    if (ts !== 3'd3 || ss !== 4'd9) begin
      errors++;
      $display("FAIL clamp_ss_only: ts=%0d ss=%0d, required 3 9", ts, ss);
    end
    load_ts = 3'd6;
    load_ss = 4'd4;
    cycle(1, 0, 0, 0);
    checks++;
    if (ts !== 3'd5 || ss !== 4'd4) begin
      errors++;
      $display("FAIL clamp_ts_only: ts=%0d ss=%0d, required 5 4", ts, ss);
    end
    $display("clamp: %0d%0d", ts, ss);
  endtask

  task automatic test_pause_resume;
    load_ts = 3'd5;
    load_ss = 4'd9;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1);
    checks++;
    if (ts !== 3'd5 || ss !== 4'd6 || running !== 1'b1) begin
      errors++;
      $display("FAIL pr_run3: ts=%0d ss=%0d run=%b, required 5 6 1", ts, ss, running);
    end
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1);
    checks++;
    if (ts !== 3'd5 || ss !== 4'd6 || running !== 1'b0) begin
      errors++;
      $display("FAIL pr_paused: ts=%0d ss=%0d run=%b, required 5 6 0", ts, ss, running);
    end
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    checks++;
    if (ts !== 3'd5 || ss !== 4'd5 || running !== 1'b1) begin
      errors++;
      $display("FAIL pr_resume: ts=%0d ss=%0d run=%b, required 5 5 1", ts, ss, running);
    end
    $display("pause/resume: %0d%0d run=%b", ts, ss, running);
  endtask

  task automatic test_edge_controls;
    // Running at 55: load is ignored.
    load_ts = 3'd1;
    load_ss = 4'd1;
    cycle(1, 0, 0, 0);
    checks++;
    if (ts !== 3'd5 || ss !== 4'd5 || running !== 1'b1) begin
      errors++;
      $display("FAIL edge_load_in_run: ts=%0d ss=%0d run=%b, required 5 5 1", ts, ss, running);
    end
    for (int k = 0; k < 15; k++) cycle(0, 0, 0, 1);
    checks++;
    if (ts !== 3'd4 || ss !== 4'd0) begin
      errors++;
      $display("FAIL edge_reach40: ts=%0d ss=%0d, required 4 0", ts, ss);
    end
    cycle(0, 1, 0, 1);
    checks++;
    if (ts !== 3'd4 || ss !== 4'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL edge_stop_enable: ts=%0d ss=%0d run=%b, required 4 0 0", ts, ss, running);
    end
    // Paused: load+stop+start -> load wins, IDLE.
    load_ts = 3'd0;
    load_ss = 4'd3;
    cycle(1, 1, 1, 0);
    checks++;
    if (ts !== 3'd0 || ss !== 4'd3 || running !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL edge_load_priority: ts=%0d ss=%0d run=%b, required 0 3 0", ts, ss, running);
    end
    // start+enable: goes to RUN with no decrement.
    cycle(0, 0, 1, 1);
    checks++;
    if (ts !== 3'd0 || ss !== 4'd3 || running !== 1'b1) begin
      errors++;
      $display("FAIL edge_start_enable: ts=%0d ss=%0d run=%b, required 0 3 1", ts, ss, running);
    end
    // Stop to PAUSE, stop to IDLE, then load 00 and try to start.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    load_ts = 3'd0;
    load_ss = 4'd0;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 1);
    checks++;
    if (running !== 1'b0 || done !== 1'b0 || alarm !== 1'b0 || ts !== 3'd0 || ss !== 4'd0) begin
      errors++;
      $display("FAIL edge_start_at_zero: run=%b done=%b alarm=%b, required 0 0 0", running, done, alarm);
    end
    $display("edge controls: %0d%0d run=%b", ts, ss, running);
  endtask

  task automatic test_alarm_cancel;
    load_ts = 3'd0;
    load_ss = 4'd2;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks++;
    if (done !== 1'b1 || alarm !== 1'b1 || ts !== 3'd0 || ss !== 4'd0) begin
      errors++;
      $display("FAIL cancel_expiry: done=%b alarm=%b ts=%0d ss=%0d, required 1 1 0 0", done, alarm, ts, ss);
    end
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL cancel_alarm_held: alarm=%b, required 1", alarm);
    end
    cycle(0, 1, 0, 0);
    checks++;
    if (alarm !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL cancel_stop: alarm=%b run=%b, required 0 0", alarm, running);
    end
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1);
    checks++;
    if (alarm !== 1'b0 || running !== 1'b0 || done !== 1'b0 || ts !== 3'd0 || ss !== 4'd0) begin
      errors++;
      $display("FAIL cancel_quiet: alarm=%b run=%b done=%b ts=%0d ss=%0d, required 0 0 0 0 0",
               alarm, running, done, ts, ss);
    end
    $display("alarm cancel: alarm=%b", alarm);
  endtask

  task automatic test_reset_midrun;
    load_ts = 3'd3;
    load_ss = 4'd0;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks++;
    if (ts !== 3'd2 || ss !== 4'd8 || running !== 1'b1) begin
      errors++;
      $display("FAIL midrun_count: ts=%0d ss=%0d run=%b, required 2 8 1", ts, ss, running);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ts !== 3'd0 || ss !== 4'd0 || running !== 1'b0 || done !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async_reset: ts=%0d ss=%0d run=%b done=%b alarm=%b, required 0 0 0 0 0",
               ts, ss, running, done, alarm);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(0, 0, 0, 1);
    checks++;
    if (ts !== 3'd0 || ss !== 4'd0 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_after_reset: ts=%0d ss=%0d run=%b done=%b, required 0 0 0 0",
               ts, ss, running, done);
    end
    $display("reset mid-run: %0d%0d", ts, ss);
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    load    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    load_ts = 3'd0;
    load_ss = 4'd0;
    test_reset();
    test_basic();
    test_clamp();
    test_pause_resume();
    test_edge_controls();
    test_alarm_cancel();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/second_countdown.md
Name: second_countdown

Overview:
- Loadable 0–59 s countdown timer: the down-counting counterpart of the team's 0–59 s up-counter (tens digit 0–5, units digit 0–9, BCD).
- Counts down one step per `enable` tick (1 Hz strobe, one clk wide, from the shared prescaler).
- Flags expiry at 00 and holds an alarm level for a programmable number of ticks.
- Sits between the front-panel control logic and the 7-segment display driver; digit outputs use the same format as the up-counter.

Parameters:
- ALARM_TICKS, 5, number of enable ticks `alarm` stays high after expiry (legal 1..255)

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- enable  input  1  1 Hz tick strobe, one clk cycle wide
- load  input  1  load preset digits (one-cycle strobe)
- start  input  1  start/resume request (one-cycle strobe)
- stop  input  1  pause/cancel request (one-cycle strobe)
- load_ts  input  3  preset tens-of-seconds digit
- load_ss  input  4  preset single-seconds digit
- ts  output  3  current tens-of-seconds digit (0–5)
- ss  output  4  current single-seconds digit (0–9)
- running  output  1  high while in RUN
- done  output  1  one-clk pulse on expiry
- alarm  output  1  high in ALARM state

Behaviour:
- Reset (async): ts=0, ss=0, state=IDLE, running=0, done=0, alarm=0, alarm tick counter=0.
- States: IDLE, RUN, PAUSE, ALARM. All outputs are registered.
- Control priority when strobes coincide: load > stop > start.
- Load:
  - Accepted in IDLE, PAUSE and ALARM; ignored in RUN.
  - Clamping: load_ts>5 loads 5; load_ss>9 loads 9. The two digits clamp independently.
  - Load in PAUSE or ALARM moves to IDLE and clears alarm.
- Stop:
  - RUN -> PAUSE; count held.
  - PAUSE -> IDLE; count retained.
  - ALARM -> IDLE; alarm cleared next cycle.
  - IDLE: no effect.
- Start:
  - IDLE or PAUSE -> RUN, but only if the count is not 00. At 00 the state stays put and done is not generated.
  - Ignored in RUN and ALARM.
- The cycle of any state transition performs no decrement, even if `enable` is high. This includes start+enable and stop+enable.
- RUN, on an enable cycle:
  - ss!=0: ss <= ss-1.
  - ss==0 and ts!=0: ss <= 9, ts <= ts-1 (borrow).
  - Count cannot be 00 in RUN.
- Expiry: the enable that takes the count from 00:01 to 00:00 also, on the same edge:
  - sets done=1 for exactly one clk;
  - sets state=ALARM and alarm=1;
  - clears the alarm tick counter.
  - done and the first 00 display appear in the same cycle.
- ALARM:
  - Each enable increments the tick counter.
  - On the ALARM_TICKS-th enable: state -> IDLE, alarm=0; ts/ss remain 00.
  - Tick counter width is ceil(log2(ALARM_TICKS+1)).
- Held levels: running=1 exactly while in RUN; alarm=1 exactly while in ALARM.
- No decrement in IDLE, PAUSE or ALARM. Digits never leave 0–5 / 0–9.
- Reset mid-operation returns immediately to the reset values above; no done pulse is emitted.

Test Plan:
- Reset: assert reset mid-cycle -> ts=0, ss=0, running=0, done=0, alarm=0 asynchronously.
- Basic countdown:
  - Stimulus: load_ts=2, load_ss=5, load; start; 25 enables.
  - Required count sequence: 25,24,…,20,19 (borrow ss 0->9, ts 2->1),…,01,00.
  - Expiry: done high for one clk on the 25th enable; alarm high for 5 further enables, then IDLE with 00.
- Clamp: load_ts=7, load_ss=12, load -> ts=5, ss=9.
- Pause/resume:
  - Stimulus: load 5/9, start, 3 enables -> 56.
  - stop, then 4 enables -> stays 56, running=0.
  - start, then 1 enable -> 55.
- Edge controls:
  - start at 00 -> stays IDLE, no done.
  - stop+enable same cycle in RUN at 40 -> PAUSE, count 40.
  - load during RUN -> ignored.
  - load+stop+start same cycle in PAUSE -> load wins, IDLE.
- Alarm cancel: during ALARM after 2 enables, stop -> alarm=0 next cycle, IDLE; further enables change nothing.
